// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and detector pair.
package pwm_pkg;

    localparam int unsigned PWM_CNT_WIDTH  = 32;
    localparam int unsigned PWM_MIN_PERIOD = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks, restartable by a synchronous clear.
module pwm_tick_gen #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic pwd_clk,
    input  logic sysreset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // With CLK_DIV=1, LAST is 0 and div_cnt never leaves 0, so tick is constant high.
    always_ff @(posedge pwd_clk or posedge sysreset) begin
        if (sysreset) begin
            div_cnt <= '0;
        end else if (clear || (div_cnt == LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: double-buffered period/high configuration applied only at period boundaries.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PWM_CNT_WIDTH,
    parameter int unsigned CLK_DIV   = 1
) (
    input  logic                 pwd_clk,
    input  logic                 sysreset,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic                 cfg_err,
    output logic                 pwm_out,
    output logic                 period_start
);

    pwm_state_e           state, state_nxt;
    logic                 pend_full, pend_full_nxt;
    logic [CNT_WIDTH-1:0] pend_period, pend_period_nxt;
    logic [CNT_WIDTH-1:0] pend_high, pend_high_nxt;
    logic [CNT_WIDTH-1:0] act_period, act_period_nxt;
    logic [CNT_WIDTH-1:0] act_high, act_high_nxt;
    logic [CNT_WIDTH-1:0] count, count_nxt;
    logic                 pwm_nxt, start_nxt, err_nxt;

    logic                 accept, reject, consume, last, tick, tick_clear;
    logic [CNT_WIDTH-1:0] high_clamped;

    assign cfg_ready    = ~pend_full;
    assign accept       = cfg_valid & ~pend_full;
    assign reject       = (cfg_period < CNT_WIDTH'(PWM_MIN_PERIOD));
    assign high_clamped = (cfg_high > cfg_period) ? cfg_period : cfg_high;
    assign last         = (count == (act_period - 1'b1));

    pwm_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .pwd_clk (pwd_clk),
        .sysreset(sysreset),
        .clear   (tick_clear),
        .tick    (tick)
    );

    always_comb begin
        state_nxt       = state;
        pend_full_nxt   = pend_full;
        pend_period_nxt = pend_period;
        pend_high_nxt   = pend_high;
        act_period_nxt  = act_period;
        act_high_nxt    = act_high;
        count_nxt       = count;
        pwm_nxt         = pwm_out;
        start_nxt       = 1'b0;
        err_nxt         = accept & reject;
        consume         = 1'b0;
        tick_clear      = 1'b0;

        case (state)
            IDLE: begin
                pwm_nxt = 1'b0;
                if (enable && pend_full) begin
                    state_nxt  = RUN;
                    consume    = 1'b1;
                    count_nxt  = '0;
                    start_nxt  = 1'b1;
                    tick_clear = 1'b1;
                end
            end
            RUN: begin
                // pwm_out trails the counter by one tick, so the last count of a
                // period is still driven on the wrap edge (including into IDLE).
                if (tick) begin
                    pwm_nxt = (count < act_high);
                    if (last) begin
                        count_nxt = '0;
                        if (enable) begin
                            start_nxt = 1'b1;
                            consume   = pend_full;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
        endcase

        if (consume) begin
            act_period_nxt = pend_period;
            act_high_nxt   = pend_high;
            pend_full_nxt  = 1'b0;
        end

        // accept needs an empty slot and consume a full one, so they never coincide.
        if (accept && !reject) begin
            pend_full_nxt   = 1'b1;
            pend_period_nxt = cfg_period;
            pend_high_nxt   = high_clamped;
        end
    end

    always_ff @(posedge pwd_clk or posedge sysreset) begin
        if (sysreset) begin
            state        <= IDLE;
            pend_full    <= 1'b0;
            pend_period  <= '0;
            pend_high    <= '0;
            act_period   <= '0;
            act_high     <= '0;
            count        <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            pend_full    <= pend_full_nxt;
            pend_period  <= pend_period_nxt;
            pend_high    <= pend_high_nxt;
            act_period   <= act_period_nxt;
            act_high     <= act_high_nxt;
            count        <= count_nxt;
            pwm_out      <= pwm_nxt;
            period_start <= start_nxt;
            cfg_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: per-cycle expectations for a CLK_DIV=1 instance, run lengths for CLK_DIV=4.
module tb_pwm_gen;

    localparam int W       = 32;
    localparam int SIG_PWM = 0;
    localparam int SIG_PS  = 1;
    localparam int SIG_RDY = 2;
    localparam int SIG_ERR = 3;

    typedef struct {
        int   cyc;
        int   sig;
        logic exp;
    } exp_t;

    typedef struct {
        logic level;
        int   len;
    } run_t;

    logic         pwd_clk = 1'b0;
    logic         sysreset, enable, cfg_valid, cfg_ready, cfg_err, pwm_out, period_start;
    logic [W-1:0] cfg_period, cfg_high;

    logic         rst4, enable4, cfg_valid4, cfg_ready4, cfg_err4, pwm_out4, period_start4;
    logic [W-1:0] cfg_period4, cfg_high4;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    run_t sb4[$];

    pwm_gen #(.CNT_WIDTH(W), .CLK_DIV(1)) dut (
        .pwd_clk     (pwd_clk),
        .sysreset    (sysreset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    pwm_gen #(.CNT_WIDTH(W), .CLK_DIV(4)) dut4 (
        .pwd_clk     (pwd_clk),
        .sysreset    (rst4),
        .enable      (enable4),
        .cfg_valid   (cfg_valid4),
        .cfg_ready   (cfg_ready4),
        .cfg_period  (cfg_period4),
        .cfg_high    (cfg_high4),
        .cfg_err     (cfg_err4),
        .pwm_out     (pwm_out4),
        .period_start(period_start4)
    );

    initial forever #5 pwd_clk = ~pwd_clk;

    initial forever begin
        @(posedge pwd_clk);
        cyc++;
    end

    function automatic string sig_name(int s);
        case (s)
            SIG_PWM: return "pwm_out";
            SIG_PS:  return "period_start";
            SIG_RDY: return "cfg_ready";
            default: return "cfg_err";
        endcase
    endfunction

    function automatic logic sig_val(int s);
        case (s)
            SIG_PWM: return pwm_out;
            SIG_PS:  return period_start;
            SIG_RDY: return cfg_ready;
            default: return cfg_err;
        endcase
    endfunction

    task automatic check_bit(string name, int c, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, c, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void expect_at(int c, int s, logic v);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sig = s;
        e.exp = v;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    // Period starting (counter = 0) at edge s0: pwm_out at s0+j shows count j-1.
    function automatic void expect_period(int s0, int p, int h);
        expect_at(s0, SIG_PS, 1'b1);
        for (int j = 1; j < p; j++) expect_at(s0 + j, SIG_PS, 1'b0);
        for (int j = 1; j <= p; j++) expect_at(s0 + j, SIG_PWM, (j - 1) < h);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge pwd_clk);
        #1;
    endtask

    task automatic step_to(int c);
        if (c > cyc) step(c - cyc);
    endtask

    task automatic offer(int at, int p, int h);
        step_to(at - 1);
        cfg_valid  = 1'b1;
        cfg_period = W'(p);
        cfg_high   = W'(h);
        step(1);
        cfg_valid = 1'b0;
    endtask

    initial forever begin
        @(negedge pwd_clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            if (sb[0].cyc == cyc) begin
                check_bit(sig_name(sb[0].sig), cyc, sig_val(sb[0].sig), sb[0].exp);
            end else begin
                check_bit({sig_name(sb[0].sig), " stale"}, sb[0].cyc, 1'bx, sb[0].exp);
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        logic prev;
        int   len;
        bit   started;
        prev    = 1'b0;
        len     = 0;
        started = 1'b0;
        forever begin
            @(negedge pwd_clk);
            if (started) begin
                if (pwm_out4 == prev) begin
                    len++;
                end else begin
                    if (sb4.size() > 0) begin
                        run_t r;
                        r = sb4.pop_front();
                        check_bit("div4 run level", cyc, prev, r.level);
                        check_int(r.level ? "div4 high run" : "div4 low run", len, r.len);
                    end
                    len = 1;
                end
            end else if (pwm_out4 && !prev) begin
                started = 1'b1;
                len     = 1;
            end
            prev = pwm_out4;
        end
    end

    initial begin
        run_t r;
        rst4        = 1'b1;
        enable4     = 1'b0;
        cfg_valid4  = 1'b0;
        cfg_period4 = '0;
        cfg_high4   = '0;
        for (int i = 0; i < 16; i++) begin
            r.level = 1'b1; r.len = 8;  sb4.push_back(r);
            r.level = 1'b0; r.len = 24; sb4.push_back(r);
        end
        step(3);
        rst4        = 1'b0;
        enable4     = 1'b1;
        cfg_valid4  = 1'b1;
        cfg_period4 = W'(8);
        cfg_high4   = W'(2);
        step(1);
        cfg_valid4 = 1'b0;
    end

    initial begin
        int k, s, s2, s3, s4, s5, k2, s6, c0;
        sysreset   = 1'b1;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        for (int c = 1; c <= 4; c++) begin
            expect_at(c, SIG_PWM, 1'b0);
            expect_at(c, SIG_PS,  1'b0);
            expect_at(c, SIG_RDY, 1'b1);
            expect_at(c, SIG_ERR, 1'b0);
        end
        step(3);
        sysreset = 1'b0;
        step(1);

        // 10/3 from IDLE: accept at k, RUN at k+1, first rise at k+2
        k = cyc + 1;
        s = k + 1;
        expect_at(k, SIG_RDY, 1'b0);
        expect_at(k, SIG_PWM, 1'b0);
        expect_at(s, SIG_RDY, 1'b1);
        expect_at(s, SIG_PWM, 1'b0);
        for (int i = 0; i < 3; i++) expect_period(s + 10 * i, 10, 3);
        enable     = 1'b1;
        cfg_valid  = 1'b1;
        cfg_period = W'(10);
        cfg_high   = W'(3);
        step(1);
        cfg_valid = 1'b0;

        // 10/7 mid-period, then 10/5 held off until the slot frees
        s2 = s + 30;
        expect_period(s2, 10, 3);
        expect_period(s2 + 10, 10, 7);
        expect_period(s2 + 20, 10, 5);
        for (int c = s2 + 5; c < s2 + 10; c++) expect_at(c, SIG_RDY, 1'b0);
        expect_at(s2 + 10, SIG_RDY, 1'b1);
        for (int c = s2 + 11; c < s2 + 20; c++) expect_at(c, SIG_RDY, 1'b0);
        expect_at(s2 + 20, SIG_RDY, 1'b1);
        step_to(s2 + 4);
        cfg_valid  = 1'b1;
        cfg_period = W'(10);
        cfg_high   = W'(7);
        step(1);
        cfg_high = W'(5);
        step_to(s2 + 11);
        cfg_valid = 1'b0;

        // high = 0, then 10, then 15 (clamped), then back to 3
        s3 = s2 + 30;
        expect_period(s3, 10, 0);
        expect_period(s3 + 10, 10, 10);
        expect_period(s3 + 20, 10, 10);
        expect_period(s3 + 30, 10, 10);
        expect_at(s2 + 25, SIG_RDY, 1'b0);
        expect_at(s3 + 15, SIG_RDY, 1'b0);
        offer(s2 + 25, 10, 0);
        offer(s3 + 5, 10, 10);
        offer(s3 + 15, 10, 15);
        offer(s3 + 35, 10, 3);

        // period = 1 rejected while running 10/3
        s4 = s3 + 40;
        expect_period(s4, 10, 3);
        expect_period(s4 + 10, 10, 3);
        expect_at(s4 + 2, SIG_ERR, 1'b0);
        expect_at(s4 + 3, SIG_ERR, 1'b1);
        expect_at(s4 + 3, SIG_RDY, 1'b1);
        expect_at(s4 + 4, SIG_ERR, 1'b0);
        expect_at(s4 + 4, SIG_RDY, 1'b1);
        offer(s4 + 3, 1, 0);

        // enable dropped at count 2: period completes, then IDLE
        s5 = s4 + 20;
        expect_period(s5, 10, 3);
        for (int c = s5 + 10; c < s5 + 15; c++) expect_at(c, SIG_PS, 1'b0);
        for (int c = s5 + 11; c < s5 + 15; c++) expect_at(c, SIG_PWM, 1'b0);
        expect_at(s5 + 12, SIG_RDY, 1'b1);
        step_to(s5 + 2);
        enable = 1'b0;

        // second run with a pending config, reset during the high phase
        step_to(s5 + 15);
        k2 = cyc + 1;
        s6 = k2 + 1;
        expect_at(k2, SIG_RDY, 1'b0);
        expect_at(s6, SIG_PS, 1'b1);
        expect_at(s6, SIG_PWM, 1'b0);
        expect_at(s6, SIG_RDY, 1'b1);
        expect_at(s6 + 1, SIG_PS, 1'b0);
        expect_at(s6 + 1, SIG_PWM, 1'b1);
        expect_at(s6 + 1, SIG_RDY, 1'b0);
        enable     = 1'b1;
        cfg_valid  = 1'b1;
        cfg_period = W'(10);
        cfg_high   = W'(3);
        step(1);
        cfg_high = W'(7);
        step(2);
        cfg_valid = 1'b0;
        step(1);
        check_bit("pwm_out before reset", cyc, pwm_out, 1'b1);
        check_bit("cfg_ready before reset", cyc, cfg_ready, 1'b0);
        sysreset = 1'b1;
        #1;
        check_bit("pwm_out async reset", cyc, pwm_out, 1'b0);
        check_bit("cfg_ready async reset", cyc, cfg_ready, 1'b1);
        check_bit("period_start async reset", cyc, period_start, 1'b0);
        step(2);
        sysreset = 1'b0;
        c0 = cyc;
        for (int c = c0 + 1; c <= c0 + 6; c++) begin
            expect_at(c, SIG_PWM, 1'b0);
            expect_at(c, SIG_PS,  1'b0);
            expect_at(c, SIG_RDY, 1'b1);
        end
        step(8);

        for (int i = 0; i < 4000 && (sb.size() > 0 || sb4.size() > 0); i++) step(1);
        if (sb.size() > 0 || sb4.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size() + sb4.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
